// File: rtl/match_stick_game_if.sv
// Player-facing bundle of the match-stick controller: dipswitch move, raw buttons
// and the display/status outputs.
interface match_stick_game_if #(
  parameter int SW_W  = 4,
  parameter int CNT_W = 7,
  parameter int PL_W  = 1
);
  logic [SW_W-1:0]  dipswitches;
  logic [1:0]       pushbuttons;
  logic [15:0]      datain;
  logic [CNT_W-1:0] remaining;
  logic [PL_W-1:0]  player;
  logic             move_err;
  logic             game_over;

  modport master (
    output dipswitches, pushbuttons,
    input  datain, remaining, player, move_err, game_over
  );

  modport slave (
    input  dipswitches, pushbuttons,
    output datain, remaining, player, move_err, game_over
  );
endinterface

// File: rtl/match_stick_game.sv
// N-player subtraction game: debounced commit/restart buttons, move validation,
// player rotation, game-over and a 4-digit word for the seven-segment driver.
module match_stick_game #(
  parameter int NUM_PLAYERS     = 2,
  parameter int START_COUNT     = 100,
  parameter int MAX_TAKE        = 10,
  parameter int SW_W            = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input logic              clk,
  input logic              rst,
  match_stick_game_if.slave bus
);
  localparam int CNT_W = $clog2(START_COUNT + 1);
  localparam int PL_W  = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CMP_W = (SW_W > CNT_W) ? SW_W : CNT_W;

  localparam logic [1:0] PLAY = 2'd0;
  localparam logic [1:0] ERR  = 2'd1;
  localparam logic [1:0] OVER = 2'd2;

  function automatic logic [11:0] to_bcd(input logic [9:0] bin);
    logic [21:0] sh;
    sh = {12'd0, bin};
    for (int i = 0; i < 10; i++) begin
      for (int d = 0; d < 3; d++) begin
        if (sh[10 + 4*d +: 4] >= 4'd5) sh[10 + 4*d +: 4] = sh[10 + 4*d +: 4] + 4'd3;
      end
      sh = sh << 1;
    end
    return sh[21:10];
  endfunction

  function automatic logic [15:0] fmt(input logic [1:0] st, input logic [CNT_W-1:0] rem,
                                      input logic [PL_W-1:0] pl);
    logic [3:0] digit;
    digit = 4'(pl) + 4'd1;
    case (st)
      ERR:     return {digit, 12'hEEE};
      OVER:    return {digit, 12'hFFF};
      default: return {digit, to_bcd(10'(rem))};
    endcase
  endfunction

  logic [1:0]      sync_p0, sync_p1, deb_p2, deb_p3;
  logic [DB_W-1:0] db_cnt [2];
  logic            commit_pls, restart_pls;

  // Stage p0/p1: synchroniser; p2: debounced level; p3: previous level for edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      deb_p2  <= '0;
      deb_p3  <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync_p0 <= bus.pushbuttons;
      sync_p1 <= sync_p0;
      deb_p3  <= deb_p2;
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] == deb_p2[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          deb_p2[i] <= sync_p1[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign commit_pls  = deb_p2[0] & ~deb_p3[0];
  assign restart_pls = deb_p2[1] & ~deb_p3[1];

  logic [1:0]       state;
  logic [CNT_W-1:0] remaining;
  logic [PL_W-1:0]  player;
  logic [CMP_W-1:0] take_w, rem_w;
  logic             valid;
  logic [CNT_W-1:0] rem_next;
  logic [PL_W-1:0]  pl_next;

  // Validity is decided at the wider of the two widths so an oversized move never aliases
  always_comb begin
    take_w   = CMP_W'(bus.dipswitches);
    rem_w    = CMP_W'(remaining);
    valid    = (take_w != '0) && (take_w <= CMP_W'(MAX_TAKE)) && (take_w <= rem_w);
    rem_next = remaining - take_w[CNT_W-1:0];
    pl_next  = (player == PL_W'(NUM_PLAYERS - 1)) ? '0 : player + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || restart_pls) begin
      state     <= PLAY;
      remaining <= CNT_W'(START_COUNT);
      player    <= '0;
    end else if (commit_pls && state != OVER) begin
      if (valid) begin
        remaining <= rem_next;
        player    <= pl_next;
        state     <= (rem_next == '0) ? OVER : PLAY;
      end else begin
        state <= ERR;
      end
    end
  end

  logic [15:0] datain_p1;

  // Stage p1: display word lags the game registers by one clock
  always_ff @(posedge clk) begin
    if (rst) datain_p1 <= fmt(PLAY, CNT_W'(START_COUNT), '0);
    else     datain_p1 <= fmt(state, remaining, player);
  end

  assign bus.datain    = datain_p1;
  assign bus.remaining = remaining;
  assign bus.player    = player;
  assign bus.move_err  = (state == ERR);
  assign bus.game_over = (state == OVER);
endmodule

// File: tb/tb_match_stick_game.sv
// Scoreboard bench for match_stick_game: a 2-player/100-stick instance and a
// 3-player/20-stick instance, both with a short debounce.
module tb_match_stick_game;
  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  match_stick_game_if #(.SW_W(4), .CNT_W(7), .PL_W(1)) bus_a ();
  match_stick_game_if #(.SW_W(4), .CNT_W(5), .PL_W(2)) bus_b ();

  match_stick_game #(.NUM_PLAYERS(2), .START_COUNT(100), .MAX_TAKE(10), .SW_W(4),
                     .DEBOUNCE_CYCLES(DB)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  match_stick_game #(.NUM_PLAYERS(3), .START_COUNT(20), .MAX_TAKE(10), .SW_W(4),
                     .DEBOUNCE_CYCLES(DB)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  typedef struct packed {
    logic        b;
    logic [47:0] w;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model, state: 0 play, 1 err, 2 over
  int m_rem[2];
  int m_pl[2];
  int m_st[2];

  task automatic model_restart(input bit b);
    m_rem[b] = b ? 20 : 100;
    m_pl[b]  = 0;
    m_st[b]  = 0;
  endtask

  task automatic model_commit(input bit b, input int ds);
    int n;
    n = b ? 3 : 2;
    if (m_st[b] == 2) return;
    if (ds >= 1 && ds <= 10 && ds <= m_rem[b]) begin
      m_rem[b] = m_rem[b] - ds;
      m_pl[b]  = (m_pl[b] + 1) % n;
      m_st[b]  = (m_rem[b] == 0) ? 2 : 0;
    end else begin
      m_st[b] = 1;
    end
  endtask

  function automatic logic [47:0] exp_word(input bit b);
    logic [15:0] d;
    d[15:12] = 4'(m_pl[b] + 1);
    if (m_st[b] == 1)      d[11:0] = 12'hEEE;
    else if (m_st[b] == 2) d[11:0] = 12'hFFF;
    else d[11:0] = {4'(m_rem[b] / 100), 4'((m_rem[b] / 10) % 10), 4'(m_rem[b] % 10)};
    return {16'(m_rem[b]), 8'(m_pl[b]), 6'd0, m_st[b] == 1, m_st[b] == 2, d};
  endfunction

  function automatic logic [47:0] observe(input bit b);
    if (b) return {16'(bus_b.remaining), 8'(bus_b.player), 6'd0,
                   bus_b.move_err, bus_b.game_over, bus_b.datain};
    return {16'(bus_a.remaining), 8'(bus_a.player), 6'd0,
            bus_a.move_err, bus_a.game_over, bus_a.datain};
  endfunction

  // Drive one press (hi cycles high, 10 low) and queue what the model predicts after it
  task automatic drive_step(input bit b, input logic [1:0] btn, input int ds, input int hi);
    exp_t e;
    @(negedge clk);
    if (b) bus_b.dipswitches = 4'(ds);
    else   bus_a.dipswitches = 4'(ds);
    if (btn[1] && hi > DB)      model_restart(b);
    else if (btn[0] && hi > DB) model_commit(b, ds);
    e.b = b;
    e.w = exp_word(b);
    exp_q.push_back(e);
    if (b) bus_b.pushbuttons = btn;
    else   bus_a.pushbuttons = btn;
    repeat (hi) @(negedge clk);
    if (b) bus_b.pushbuttons = 2'b00;
    else   bus_a.pushbuttons = 2'b00;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    exp_t e;
    logic [47:0] got;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_restart(0);
    model_restart(1);
    for (int b = 0; b < 2; b++) begin
      e.b = 1'(b);
      e.w = exp_word(1'(b));
      exp_q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      got = observe(e.b);
      checks++;
      if (got !== e.w) begin
        errors++;
        $display("FAIL reset[%0d]: got {rem,pl,flags,datain}=%h want %h", i, got, e.w);
      end
    end
  endtask

  task automatic test_valid_moves();
    int ds_t[2] = '{7, 10};
    exp_t e;
    logic [47:0] got;
    for (int i = 0; i < 2; i++) begin
      drive_step(0, 2'b01, ds_t[i], 10);
      e = exp_q.pop_front();
      got = observe(e.b);
      checks++;
      if (got !== e.w) begin
        errors++;
        $display("FAIL valid[%0d]: got {rem,pl,flags,datain}=%h want %h", i, got, e.w);
      end
    end
  endtask

  task automatic test_invalid_moves();
    int ds_t[3] = '{0, 11, 3};
    exp_t e;
    logic [47:0] got;
    for (int i = 0; i < 3; i++) begin
      drive_step(0, 2'b01, ds_t[i], 10);
      e = exp_q.pop_front();
      got = observe(e.b);
      checks++;
      if (got !== e.w) begin
        errors++;
        $display("FAIL invalid[%0d]: got {rem,pl,flags,datain}=%h want %h", i, got, e.w);
      end
    end
  endtask

  task automatic test_game_over();
    logic [1:0] btn_t[15] = '{2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01,
                              2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    int ds_t[15] = '{0, 10, 10, 10, 10, 10, 10, 10, 10, 10, 8, 5, 2, 1, 0};
    exp_t e;
    logic [47:0] got;
    for (int i = 0; i < 15; i++) begin
      drive_step(0, btn_t[i], ds_t[i], 10);
      e = exp_q.pop_front();
      got = observe(e.b);
      checks++;
      if (got !== e.w) begin
        errors++;
        $display("FAIL game_over[%0d]: got {rem,pl,flags,datain}=%h want %h", i, got, e.w);
      end
    end
  endtask

  task automatic test_glitch_and_hold();
    logic [1:0] btn_t[4] = '{2'b01, 2'b01, 2'b11, 2'b01};
    int hi_t[4] = '{10, 2, 10, 200};
    int ds_t[4] = '{4, 4, 4, 4};
    exp_t e;
    logic [47:0] got;
    for (int i = 0; i < 4; i++) begin
      drive_step(0, btn_t[i], ds_t[i], hi_t[i]);
      e = exp_q.pop_front();
      got = observe(e.b);
      checks++;
      if (got !== e.w) begin
        errors++;
        $display("FAIL glitch_hold[%0d]: got {rem,pl,flags,datain}=%h want %h", i, got, e.w);
      end
    end
  endtask

  task automatic test_three_players();
    int ds_t[3] = '{3, 4, 5};
    exp_t e;
    logic [47:0] got;
    for (int i = 0; i < 3; i++) begin
      drive_step(1, 2'b01, ds_t[i], 10);
      e = exp_q.pop_front();
      got = observe(e.b);
      checks++;
      if (got !== e.w) begin
        errors++;
        $display("FAIL three_players[%0d]: got {rem,pl,flags,datain}=%h want %h", i, got, e.w);
      end
    end
  endtask

  initial begin
    bus_a.dipswitches = '0;
    bus_a.pushbuttons = '0;
    bus_b.dipswitches = '0;
    bus_b.pushbuttons = '0;
    test_reset();
    test_valid_moves();
    test_invalid_moves();
    test_game_over();
    test_glitch_and_hold();
    test_three_players();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
